// File: rtl/fpu_pkg.sv
// Shared types and constants for the sequential FP add/sub unit.
// Build option FPU_DIRECTED_ROUND_EN enables the three directed rounding modes.
package fpu_pkg;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int BIAS   = 127;

   localparam logic [31:0] QNAN       = 32'h7FC00000;
   localparam logic [31:0] POS_INF    = 32'h7F800000;
   localparam logic [31:0] MAX_FINITE = 32'h7F7FFFFF;

   localparam logic [1:0] SEL_ADD = 2'b00;
   localparam logic [1:0] SEL_SUB = 2'b01;

   localparam logic [1:0] RND_RNE = 2'b00;
   localparam logic [1:0] RND_RTZ = 2'b01;
   localparam logic [1:0] RND_RUP = 2'b10;
   localparam logic [1:0] RND_RDN = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_UNPACK,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_ROUND
   } state_e;

   // Saturated result when the exponent overflows, chosen by rounding direction.
   function automatic logic [31:0] ovf_word(input logic s, input logic [1:0] m);
      logic [31:0] w;
      unique case (m)
         RND_RTZ: w = {s, MAX_FINITE[30:0]};
         RND_RUP: w = s ? {1'b1, MAX_FINITE[30:0]} : POS_INF;
         RND_RDN: w = s ? {1'b1, POS_INF[30:0]} : MAX_FINITE;
         default: w = {s, POS_INF[30:0]};
      endcase
      return w;
   endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational 28-bit leading-zero counter; all-zero input gives 28.
module fpu_lzc (
   input  logic [27:0] d_i,
   output logic [4:0]  cnt_o
);

   always_comb begin
      cnt_o = 5'd28;
      for (int i = 0; i < 28; i++) begin
         if (d_i[i]) cnt_o = 5'(27 - i);
      end
   end

endmodule

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle single-precision add/subtract, one stage per FSM state.
// FPU_DIRECTED_ROUND_EN: honour the round input; otherwise nearest-even only.
module fpu_addsub_seq
   import fpu_pkg::*;
#(
   parameter int LATENCY = 6
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [1:0]  Sel,
   input  logic [1:0]  round,
   output logic        busy,
   output logic        done,
   output logic [31:0] Y,
   output logic        Overflow,
   output logic        Error
);

   localparam int LAT = (LATENCY < 6) ? 6 : LATENCY;

   state_e      state_q;
   logic [7:0]  cnt_q;
   logic [31:0] a_q, b_q;
   logic [1:0]  sel_q, rnd_q;
   logic        sa_q, sb_q, err_q;
   logic [EXP_W-1:0]  ea_q, eb_q, ex_q;
   logic [FRAC_W:0]   ma_q, mb_q;
   logic        sx_q, sy_q;
   logic [26:0] mx_q, my_q;
   logic [27:0] sum_q;
   logic        sgn_q, zero_q;
   logic signed [9:0] es_q, ne_q;
   logic [26:0] nm_q;
   logic        busy_q, done_q, ovf_q, erro_q;
   logic [31:0] y_q;

`ifndef FPU_DIRECTED_ROUND_EN
   logic unused_round;
   assign unused_round = ^round;
`endif

   logic [EXP_W-1:0] ua_e, ub_e;
   logic [FRAC_W:0]  ua_m, ub_m;
   logic             ub_s, u_err;

   always_comb begin
      ua_e  = a_q[30:23];
      ub_e  = b_q[30:23];
      ua_m  = (ua_e == '0) ? '0 : {1'b1, a_q[22:0]};
      ub_m  = (ub_e == '0) ? '0 : {1'b1, b_q[22:0]};
      ub_s  = b_q[31] ^ (sel_q == SEL_SUB);
      u_err = (&ua_e) | (&ub_e) | sel_q[1];
   end

   logic             a_big, al_sx, al_sy;
   logic [EXP_W-1:0] al_ex, al_ey, al_d;
   logic [26:0]      al_mx, al_y, al_my;

   always_comb begin
      a_big = {ea_q, ma_q} >= {eb_q, mb_q};
      al_ex = a_big ? ea_q : eb_q;
      al_ey = a_big ? eb_q : ea_q;
      al_sx = a_big ? sa_q : sb_q;
      al_sy = a_big ? sb_q : sa_q;
      al_mx = {(a_big ? ma_q : mb_q), 3'b000};
      al_y  = {(a_big ? mb_q : ma_q), 3'b000};
      al_d  = al_ex - al_ey;
      // Bits shifted past the window survive only as sticky.
      if (al_d >= 8'd27) al_my = {26'd0, |al_y};
      else al_my = (al_y >> al_d)
                 | {26'd0, |(al_y & ((27'd1 << al_d) - 27'd1))};
   end

   logic [27:0] ad_sum;

   always_comb begin
      if (sx_q == sy_q) ad_sum = {1'b0, mx_q} + {1'b0, my_q};
      else ad_sum = {1'b0, mx_q} - {1'b0, my_q};
   end

   logic [4:0]        lz, nm_sh;
   logic [26:0]       nm_d;
   logic signed [9:0] ne_d;

   fpu_lzc u_lzc (
      .d_i   (sum_q),
      .cnt_o (lz)
   );

   always_comb begin
      nm_sh = lz - 5'd1;
      if (sum_q[27]) begin
         nm_d = sum_q[27:1] | {26'd0, sum_q[0]};
         ne_d = es_q + 10'sd1;
      end else begin
         nm_d = sum_q[26:0] << nm_sh;
         ne_d = es_q - $signed({5'd0, nm_sh});
      end
   end

   logic              g, rs, inc;
   logic [24:0]       rm;
   logic [FRAC_W-1:0] rf;
   logic signed [9:0] re;
   logic [31:0]       r_y;
   logic              r_ovf, r_err;

   always_comb begin
      g  = nm_q[2];
      rs = nm_q[1] | nm_q[0];
      unique case (rnd_q)
         RND_RTZ: inc = 1'b0;
         RND_RUP: inc = ~sgn_q & (g | rs);
         RND_RDN: inc = sgn_q & (g | rs);
         default: inc = g & (rs | nm_q[3]);
      endcase
      rm = {1'b0, nm_q[26:3]} + {24'd0, inc};
      if (rm[24]) begin
         rf = rm[23:1];
         re = ne_q + 10'sd1;
      end else begin
         rf = rm[22:0];
         re = ne_q;
      end
      r_y   = {sgn_q, re[7:0], rf};
      r_ovf = 1'b0;
      r_err = 1'b0;
      if (err_q) begin
         r_y   = QNAN;
         r_err = 1'b1;
      end else if (zero_q) begin
         r_y = {(rnd_q == RND_RDN), 31'd0};
      end else if (re <= 10'sd0) begin
         r_y = {sgn_q, 31'd0};
      end else if (re >= 10'(2 * BIAS + 1)) begin
         r_y   = ovf_word(sgn_q, rnd_q);
         r_ovf = 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= '0;
         rnd_q   <= RND_RNE;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         err_q   <= 1'b0;
         ea_q    <= '0;
         eb_q    <= '0;
         ma_q    <= '0;
         mb_q    <= '0;
         sx_q    <= 1'b0;
         sy_q    <= 1'b0;
         ex_q    <= '0;
         mx_q    <= '0;
         my_q    <= '0;
         sum_q   <= '0;
         sgn_q   <= 1'b0;
         es_q    <= '0;
         nm_q    <= '0;
         ne_q    <= '0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         y_q     <= '0;
         ovf_q   <= 1'b0;
         erro_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (busy_q) cnt_q <= cnt_q + 8'd1;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q    <= A;
                  b_q    <= B;
                  sel_q  <= Sel;
`ifdef FPU_DIRECTED_ROUND_EN
                  rnd_q  <= round;
`else
                  rnd_q  <= RND_RNE;
`endif
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_UNPACK;
               end
            end
            S_UNPACK: begin
               sa_q    <= a_q[31];
               sb_q    <= ub_s;
               ea_q    <= ua_e;
               eb_q    <= ub_e;
               ma_q    <= ua_m;
               mb_q    <= ub_m;
               err_q   <= u_err;
               state_q <= S_ALIGN;
            end
            S_ALIGN: begin
               sx_q    <= al_sx;
               sy_q    <= al_sy;
               ex_q    <= al_ex;
               mx_q    <= al_mx;
               my_q    <= al_my;
               state_q <= S_ADD;
            end
            S_ADD: begin
               sum_q   <= ad_sum;
               sgn_q   <= sx_q;
               es_q    <= $signed({2'b00, ex_q});
               state_q <= S_NORM;
            end
            S_NORM: begin
               nm_q    <= nm_d;
               ne_q    <= ne_d;
               zero_q  <= (sum_q == '0);
               state_q <= S_ROUND;
            end
            S_ROUND: begin
               // Dwell here until the fixed latency has elapsed.
               if (cnt_q == 8'(LAT - 1)) begin
                  y_q     <= r_y;
                  ovf_q   <= r_ovf;
                  erro_q  <= r_err;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign Y        = y_q;
   assign Overflow = ovf_q;
   assign Error    = erro_q;

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Directed self-checking bench for fpu_addsub_seq.
// Expected rounding results follow the FPU_DIRECTED_ROUND_EN build setting.
module tb_fpu_addsub_seq;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic [1:0]  Sel = '0;
   logic [1:0]  round = '0;
   logic        busy, done, Overflow, Error;
   logic [31:0] Y;

   int checks = 0;
   int errors = 0;

`ifdef FPU_DIRECTED_ROUND_EN
   localparam logic [31:0] E_RUP = 32'h3F800001;
   localparam logic [31:0] E_RDN = 32'hBF800001;
   localparam logic [31:0] E_OVZ = 32'h7F7FFFFF;
   localparam logic [31:0] E_ZN  = 32'h80000000;
`else
   localparam logic [31:0] E_RUP = 32'h3F800000;
   localparam logic [31:0] E_RDN = 32'hBF800000;
   localparam logic [31:0] E_OVZ = 32'h7F800000;
   localparam logic [31:0] E_ZN  = 32'h00000000;
`endif

   fpu_addsub_seq #(.LATENCY(6)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .start    (start),
      .A        (A),
      .B        (B),
      .Sel      (Sel),
      .round    (round),
      .busy     (busy),
      .done     (done),
      .Y        (Y),
      .Overflow (Overflow),
      .Error    (Error)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic run(input string tag, input logic [31:0] a, b,
                      input logic [1:0] sel, rnd, input logic [31:0] ey,
                      input logic eo, ee);
      int lat;
      @(negedge Clock);
      A = a; B = b; Sel = sel; round = rnd; start = 1'b1;
      @(posedge Clock);
      #1;
      start = 1'b0;
      A = 32'h12345678; B = 32'h3F800000; Sel = 2'b00; round = 2'b01;
      chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
      lat = 0;
      while (done !== 1'b1 && lat < 20) begin
         @(posedge Clock);
         #1;
         lat++;
      end
      chk({tag, ".lat"}, 32'(lat), 32'd6);
      chk({tag, ".y"}, Y, ey);
      chk({tag, ".ovf"}, {31'd0, Overflow}, {31'd0, eo});
      chk({tag, ".err"}, {31'd0, Error}, {31'd0, ee});
      chk({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
      @(posedge Clock);
      #1;
      chk({tag, ".pulse"}, {31'd0, done}, 32'd0);
      chk({tag, ".hold"}, Y, ey);
   endtask

   initial begin
      int ndone;
      #2 Reset = 1'b0;
      repeat (3) @(posedge Clock);
      #1;
      chk("rst.busy", {31'd0, busy}, 32'd0);
      chk("rst.done", {31'd0, done}, 32'd0);
      chk("rst.y", Y, 32'd0);
      chk("rst.ovf", {31'd0, Overflow}, 32'd0);
      chk("rst.err", {31'd0, Error}, 32'd0);
      @(negedge Clock);
      Reset = 1'b1;

      run("add", 32'h43700000, 32'h42F00000, 2'b00, 2'b00, 32'h43B40000, 0, 0);
      run("sub", 32'h43700000, 32'h42F00000, 2'b01, 2'b00, 32'h42F00000, 0, 0);

      run("tie_rne", 32'h3F800000, 32'h33800000, 2'b00, 2'b00, 32'h3F800000, 0, 0);
      run("tie_rtz", 32'h3F800000, 32'h33800000, 2'b00, 2'b01, 32'h3F800000, 0, 0);
      run("tie_rup", 32'h3F800000, 32'h33800000, 2'b00, 2'b10, E_RUP, 0, 0);
      run("tie_rdn", 32'hBF800000, 32'hB3800000, 2'b00, 2'b11, E_RDN, 0, 0);

      run("ovf_rne", 32'h7F010000, 32'h7F010000, 2'b00, 2'b00, 32'h7F800000, 1, 0);
      run("ovf_rtz", 32'h7F010000, 32'h7F010000, 2'b00, 2'b01, E_OVZ, 1, 0);

      run("zero", 32'h7F010000, 32'h7F010000, 2'b01, 2'b00, 32'h00000000, 0, 0);
      run("zero_rdn", 32'h7F010000, 32'h7F010000, 2'b01, 2'b11, E_ZN, 0, 0);

      run("inf_err", 32'h7F800000, 32'hFF800000, 2'b00, 2'b00, 32'h7FC00000, 0, 1);
      run("sel_err", 32'h3F800000, 32'h3F800000, 2'b10, 2'b00, 32'h7FC00000, 0, 1);

      // Re-asserting start while busy must not launch a second operation.
      @(negedge Clock);
      A = 32'h43700000; B = 32'h42F00000; Sel = 2'b00; round = 2'b00;
      start = 1'b1;
      @(posedge Clock);
      #1;
      A = 32'h7F800000; Sel = 2'b10;
      ndone = 0;
      for (int i = 1; i <= 14; i++) begin
         if (i == 4) start = 1'b0;
         @(posedge Clock);
         #1;
         if (done === 1'b1) ndone++;
      end
      chk("busy_ign.ndone", 32'(ndone), 32'd1);
      chk("busy_ign.y", Y, 32'h43B40000);
      chk("busy_ign.err", {31'd0, Error}, 32'd0);

      // Reset during an operation aborts it with no done.
      @(negedge Clock);
      A = 32'h7F010000; B = 32'h7F010000; Sel = 2'b00; round = 2'b00;
      start = 1'b1;
      @(posedge Clock);
      #1;
      start = 1'b0;
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      #1;
      chk("midrst.busy", {31'd0, busy}, 32'd0);
      chk("midrst.done", {31'd0, done}, 32'd0);
      chk("midrst.y", Y, 32'd0);
      chk("midrst.ovf", {31'd0, Overflow}, 32'd0);
      chk("midrst.err", {31'd0, Error}, 32'd0);
      @(negedge Clock);
      Reset = 1'b1;
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge Clock);
         #1;
         if (done === 1'b1) ndone++;
      end
      chk("midrst.ndone", 32'(ndone), 32'd0);
      chk("midrst.y_after", Y, 32'd0);

      run("post_rst", 32'h43700000, 32'h42F00000, 2'b01, 2'b00, 32'h42F00000, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
